// File: rtl/exe_mdu_stage.sv
// exe_mdu_stage: EX stage with ALU, branch resolution, EX/MEM register and optional iterative MDU (enable with EXE_MDU_EN)
module exe_mdu_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [4:0]  Dest_in,
  input  logic [31:0] Reg2_in,
  input  logic [31:0] Val1_in,
  input  logic [31:0] Val2_in,
  input  logic [31:0] PC_in,
  input  logic [1:0]  Br_type_in,
  input  logic [3:0]  EXE_CMD_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic        WB_EN_in,
  output logic [31:0] ALU_result,
  output logic [31:0] Reg2_out,
  output logic [4:0]  Dest,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic        WB_EN,
  output logic        Br_taken,
  output logic [31:0] Br_addr,
  output logic        stall
);
  logic [31:0] alu, res_sel, res_d, res_q, reg2_d, reg2_q;
  logic [4:0]  sh, dest_d, dest_q;
  logic        bubble, mr_d, mr_q, mw_d, mw_q, wb_d, wb_q;
  assign sh = Val2_in[4:0];
  // single-cycle ALU; unlisted codes (and MDU codes when the MDU is absent) give 0
  always_comb begin
    alu = EXE_CMD_in == 4'b0000 ? Val1_in + Val2_in :
          EXE_CMD_in == 4'b0010 ? Val1_in - Val2_in :
          EXE_CMD_in == 4'b0100 ? Val1_in & Val2_in :
          EXE_CMD_in == 4'b0101 ? Val1_in | Val2_in :
          EXE_CMD_in == 4'b0110 ? ~(Val1_in | Val2_in) :
          EXE_CMD_in == 4'b0111 ? Val1_in ^ Val2_in :
          EXE_CMD_in == 4'b1000 ? Val1_in << sh :
          EXE_CMD_in == 4'b1001 ? $unsigned($signed(Val1_in) >>> sh) :
          EXE_CMD_in == 4'b1010 ? Val1_in >> sh : 32'd0;
  end
  // branch decision and target, both combinational
  always_comb begin
    Br_taken = valid_in & (Br_type_in == 2'd1 ? Val1_in == 32'd0 :
                           Br_type_in == 2'd2 ? Val1_in != Reg2_in :
                           Br_type_in == 2'd3);
    Br_addr  = PC_in + {Val2_in[29:0], 2'b00};
  end
`ifdef EXE_MDU_EN
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]  state_d, state_q, op_d, op_q;
  logic [4:0]  cnt_d, cnt_q;
  logic [31:0] acc_d, acc_q, a_d, a_q, q_d, q_q, mdu_res;
  logic [32:0] rsh, rdiff;
  logic        is_mdu, accept;
  assign is_mdu  = EXE_CMD_in[3:2] == 2'b11 && EXE_CMD_in[1:0] != 2'b11;
  assign accept  = state_q == IDLE && valid_in && is_mdu;
  assign stall   = !rst && (accept || state_q == BUSY);
  assign mdu_res = op_q == 2'd1 ? q_q : acc_q;
  assign bubble  = state_q != DONE && (stall || !valid_in);
  assign res_sel = state_q == DONE ? mdu_res : alu;
  // restoring division: shift in the next dividend bit, subtract when the divisor fits;
  // a zero divisor always fits, giving all-ones quotient and the dividend as remainder
  assign rsh   = {acc_q, q_q[31]};
  assign rdiff = rsh - {1'b0, a_q};
  // FSM and one shift-add / divide step per BUSY cycle; operands captured only on accept
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    a_d     = a_q;
    q_d     = q_q;
    if (accept) begin
      state_d = BUSY;
      cnt_d   = 5'd0;
      op_d    = EXE_CMD_in[1:0];
      acc_d   = 32'd0;
      a_d     = Val2_in;
      q_d     = Val1_in;
    end else if (state_q == BUSY) begin
      cnt_d   = cnt_q + 5'd1;
      state_d = cnt_q == 5'd31 ? DONE : BUSY;
      acc_d   = op_q == 2'd0 ? acc_q + (q_q[0] ? a_q : 32'd0) :
                rdiff[32] ? rsh[31:0] : rdiff[31:0];
      a_d     = op_q == 2'd0 ? a_q << 1 : a_q;
      q_d     = op_q == 2'd0 ? q_q >> 1 : {q_q[30:0], ~rdiff[32]};
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // FSM and datapath state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 2'd0;
      acc_q   <= 32'd0;
      a_q     <= 32'd0;
      q_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      q_q     <= q_d;
    end
  end
`else
  assign stall   = 1'b0;
  assign bubble  = !valid_in;
  assign res_sel = alu;
`endif
  // next EX/MEM contents: a bubble clears every field
  always_comb begin
    res_d  = bubble ? 32'd0 : res_sel;
    reg2_d = bubble ? 32'd0 : Reg2_in;
    dest_d = bubble ? 5'd0 : Dest_in;
    mr_d   = !bubble && MEM_R_EN_in;
    mw_d   = !bubble && MEM_W_EN_in;
    wb_d   = !bubble && WB_EN_in;
  end
  // EX/MEM pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= 32'd0;
      reg2_q <= 32'd0;
      dest_q <= 5'd0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      wb_q   <= 1'b0;
    end else begin
      res_q  <= res_d;
      reg2_q <= reg2_d;
      dest_q <= dest_d;
      mr_q   <= mr_d;
      mw_q   <= mw_d;
      wb_q   <= wb_d;
    end
  end
  assign ALU_result = res_q;
  assign Reg2_out   = reg2_q;
  assign Dest       = dest_q;
  assign MEM_R_EN   = mr_q;
  assign MEM_W_EN   = mw_q;
  assign WB_EN      = wb_q;
endmodule

// File: tb/tb_exe_mdu_stage.sv
// tb_exe_mdu_stage: randomized self-checking bench for exe_mdu_stage against a behavioural model
module tb_exe_mdu_stage;
  logic        clk = 0, rst = 1, valid_in = 0;
  logic [4:0]  Dest_in = 0;
  logic [31:0] Reg2_in = 0, Val1_in = 0, Val2_in = 0, PC_in = 0;
  logic [1:0]  Br_type_in = 0;
  logic [3:0]  EXE_CMD_in = 0;
  logic        MEM_R_EN_in = 0, MEM_W_EN_in = 0, WB_EN_in = 0;
  logic [31:0] ALU_result, Reg2_out, Br_addr;
  logic [4:0]  Dest;
  logic        MEM_R_EN, MEM_W_EN, WB_EN, Br_taken, stall;
  int          n_chk = 0, n_fail = 0;

  exe_mdu_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .Dest_in(Dest_in), .Reg2_in(Reg2_in),
    .Val1_in(Val1_in), .Val2_in(Val2_in), .PC_in(PC_in), .Br_type_in(Br_type_in),
    .EXE_CMD_in(EXE_CMD_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .WB_EN_in(WB_EN_in), .ALU_result(ALU_result), .Reg2_out(Reg2_out), .Dest(Dest),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .Br_taken(Br_taken),
    .Br_addr(Br_addr), .stall(stall)
  );

  always #5 clk = ~clk;

`ifdef EXE_MDU_EN
  localparam bit MDU = 1;
`else
  localparam bit MDU = 0;
`endif

  function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ext;
    ext = {{32{a[31]}}, a} >> b[4:0];
    case (cmd)
      4'd0:  return a + b;
      4'd2:  return a - b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return ~(a | b);
      4'd7:  return a ^ b;
      4'd8:  return a << b[4:0];
      4'd9:  return ext[31:0];
      4'd10: return a >> b[4:0];
      4'd12: return MDU ? a * b : 32'd0;
      4'd13: return !MDU ? 32'd0 : b == 0 ? 32'hFFFFFFFF : a / b;
      4'd14: return !MDU ? 32'd0 : b == 0 ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r2, input logic [4:0] d, input logic [2:0] en);
    valid_in = v; EXE_CMD_in = cmd; Val1_in = a; Val2_in = b; Reg2_in = r2; Dest_in = d;
    {MEM_R_EN_in, MEM_W_EN_in, WB_EN_in} = en;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    n_chk++;
    if ({ALU_result, Reg2_out, Dest, MEM_R_EN, MEM_W_EN, WB_EN, stall} !== '0) begin
      n_fail++; $display("FAIL reset_state got res=%h r2=%h d=%0d en=%b%b%b stall=%b want all 0",
        ALU_result, Reg2_out, Dest, MEM_R_EN, MEM_W_EN, WB_EN, stall);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_add_wrap;
    drive(1, 4'd0, 32'h7FFFFFFF, 32'd1, 32'h55, 5'd9, 3'b001);
    #1;
    n_chk++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL add_stall got %b want 0", stall); end
    tick();
    n_chk++;
    if (ALU_result !== 32'h80000000 || WB_EN !== 1'b1 || Dest !== 5'd9) begin
      n_fail++; $display("FAIL add_wrap got res=%h wb=%b d=%0d want 80000000 1 9", ALU_result, WB_EN, Dest);
    end
    drive(0, 0, 0, 0, 0, 0, 3'b111);
    tick();
    n_chk++;
    if ({MEM_R_EN, MEM_W_EN, WB_EN} !== 3'b000) begin
      n_fail++; $display("FAIL bubble got en=%b%b%b want 000", MEM_R_EN, MEM_W_EN, WB_EN);
    end
  endtask

  task automatic test_alu_random;
    for (int i = 0; i < 60; i++) begin
      logic [3:0] cmd;
      logic [31:0] a, b, r2, exp;
      logic [4:0] d;
      logic [2:0] en;
      logic v;
      cmd = 4'($urandom_range(0, 15));
      if (MDU && cmd >= 4'd12 && cmd <= 4'd14) cmd = 4'd7;
      a = $urandom; b = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      r2 = $urandom; d = 5'($urandom); en = 3'($urandom); v = ($urandom_range(0, 4) != 0);
      exp = ref_alu(cmd, a, b);
      drive(v, cmd, a, b, r2, d, en);
      #1;
      n_chk++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall cmd=%h got %b want 0", cmd, stall); end
      tick();
      n_chk++;
      if (v && (ALU_result !== exp || Reg2_out !== r2 || Dest !== d || {MEM_R_EN, MEM_W_EN, WB_EN} !== en)) begin
        n_fail++; $display("FAIL alu cmd=%h a=%h b=%h got res=%h r2=%h d=%0d en=%b%b%b want %h %h %0d %b",
          cmd, a, b, ALU_result, Reg2_out, Dest, MEM_R_EN, MEM_W_EN, WB_EN, exp, r2, d, en);
      end else if (!v && {MEM_R_EN, MEM_W_EN, WB_EN} !== 3'b000) begin
        n_fail++; $display("FAIL alu_bubble got en=%b%b%b want 000", MEM_R_EN, MEM_W_EN, WB_EN);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_branch;
    logic [31:0] pcs[3]  = '{32'h0, 32'h100, 32'h0};
    logic [31:0] v1s[3]  = '{32'd5, 32'd0, 32'd0};
    logic [31:0] v2s[3]  = '{32'd0, 32'hFFFFFFFE, 32'd0};
    logic [31:0] r2s[3]  = '{32'd5, 32'd0, 32'd0};
    logic [1:0]  brs[3]  = '{2'd2, 2'd1, 2'd3};
    logic        vs[3]   = '{1'b1, 1'b1, 1'b0};
    logic        tk[3]   = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      valid_in = vs[i]; PC_in = pcs[i]; Val1_in = v1s[i]; Val2_in = v2s[i]; Reg2_in = r2s[i]; Br_type_in = brs[i];
      EXE_CMD_in = 0;
      #1;
      n_chk++;
      if (Br_taken !== tk[i]) begin n_fail++; $display("FAIL br_vec%0d taken got %b want %b", i, Br_taken, tk[i]); end
    end
    PC_in = 32'h100; Val2_in = 32'hFFFFFFFE; valid_in = 1;
    #1;
    n_chk++;
    if (Br_addr !== 32'h0F8) begin n_fail++; $display("FAIL br_addr got %h want 000000f8", Br_addr); end
    for (int i = 0; i < 40; i++) begin
      logic exp_t;
      logic [31:0] exp_a;
      valid_in = $urandom_range(0, 3) != 0; Br_type_in = 2'($urandom);
      Val1_in = $urandom_range(0, 1) ? 32'd0 : $urandom; Reg2_in = $urandom_range(0, 1) ? Val1_in : $urandom;
      Val2_in = $urandom; PC_in = $urandom;
      exp_t = valid_in && ((Br_type_in == 1 && Val1_in == 0) || (Br_type_in == 2 && Val1_in != Reg2_in) || Br_type_in == 3);
      exp_a = 32'(64'(PC_in) + 64'(Val2_in) * 4);
      #1;
      n_chk++;
      if (Br_taken !== exp_t || Br_addr !== exp_a) begin
        n_fail++; $display("FAIL br_rand type=%0d got %b %h want %b %h", Br_type_in, Br_taken, Br_addr, exp_t, exp_a);
      end
      #4;
    end
    Br_type_in = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid;
    drive(1, 4'd0, 32'd10, 32'd20, 32'd7, 5'd3, 3'b111);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1;
    #1;
    n_chk++;
    if ({ALU_result, Reg2_out, Dest, MEM_R_EN, MEM_W_EN, WB_EN, stall} !== '0) begin
      n_fail++; $display("FAIL async_reset got res=%h en=%b%b%b stall=%b want 0", ALU_result, MEM_R_EN, MEM_W_EN, WB_EN, stall);
    end
    tick();
    rst = 0;
    drive(1, 4'd0, 32'd2, 32'd3, 32'd0, 5'd1, 3'b001);
    tick();
    n_chk++;
    if (ALU_result !== 32'd5 || WB_EN !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_add got res=%h wb=%b want 5 1", ALU_result, WB_EN);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

`ifdef EXE_MDU_EN
  task automatic run_mdu(input string nm, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    logic [4:0] d;
    int n, bub;
    exp = ref_alu(cmd, a, b); d = 5'($urandom_range(1, 31)); n = 0; bub = 0;
    drive(1, cmd, a, b, 32'hCAFE, d, 3'b001);
    #1;
    while (stall === 1'b1 && n < 100) begin
      n++;
      tick();
      if (WB_EN !== 1'b0) bub++;
    end
    n_chk++;
    if (n != 33 || bub != 0) begin n_fail++; $display("FAIL %s_stall got %0d cycles %0d non-bubbles want 33 0", nm, n, bub); end
    tick();
    n_chk++;
    if (ALU_result !== exp || WB_EN !== 1'b1 || Dest !== d) begin
      n_fail++; $display("FAIL %s_result a=%h b=%h got %h wb=%b d=%0d want %h 1 %0d", nm, a, b, ALU_result, WB_EN, Dest, exp, d);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_mdu;
    run_mdu("mul", 4'd12, 32'h00010003, 32'h00020005);
    run_mdu("divu0", 4'd13, 32'h1234, 32'd0);
    run_mdu("remu0", 4'd14, 32'h1234, 32'd0);
    for (int i = 0; i < 9; i++) run_mdu("mdu_rand", 4'(12 + i % 3), $urandom, (i > 5) ? 32'($urandom_range(1, 300)) : $urandom);
  endtask

  task automatic test_back_to_back;
    int n;
    drive(1, 4'd12, 32'd6, 32'd7, 0, 5'd2, 3'b001);
    n = 0;
    #1;
    while (stall === 1'b1 && n < 100) begin n++; tick(); end
    n_chk++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_done_stall got %b want 0", stall); end
    tick();
    drive(1, 4'd13, 32'd100, 32'd7, 0, 5'd4, 3'b001);
    #1;
    n_chk++;
    if (ALU_result !== 32'd42 || stall !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first got res=%0d stall=%b want 42 1", ALU_result, stall);
    end
    n = 0;
    while (stall === 1'b1 && n < 100) begin n++; tick(); end
    tick();
    n_chk++;
    if (n != 33 || ALU_result !== 32'd14) begin
      n_fail++; $display("FAIL b2b_second got %0d cycles res=%0d want 33 14", n, ALU_result);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_busy;
    int bad;
    drive(1, 4'd12, 32'd9, 32'd9, 0, 5'd5, 3'b001);
    repeat (11) tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1;
    #1;
    n_chk++;
    if (stall !== 1'b0 || ALU_result !== 32'd0 || WB_EN !== 1'b0) begin
      n_fail++; $display("FAIL busy_reset got stall=%b res=%h wb=%b want 0 0 0", stall, ALU_result, WB_EN);
    end
    tick();
    rst = 0;
    drive(1, 4'd0, 32'd2, 32'd3, 0, 5'd1, 3'b001);
    #1;
    n_chk++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL busy_reset_stall got %b want 0", stall); end
    tick();
    n_chk++;
    if (ALU_result !== 32'd5) begin n_fail++; $display("FAIL busy_reset_add got %h want 5", ALU_result); end
    drive(0, 0, 0, 0, 0, 0, 0);
    bad = 0;
    repeat (40) begin tick(); if (WB_EN !== 1'b0 || stall !== 1'b0) bad++; end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL aborted_writeback got %0d bad cycles want 0", bad); end
  endtask
`else
  task automatic test_no_mdu;
    logic [3:0] cmds[3] = '{4'd12, 4'd13, 4'd14};
    for (int i = 0; i < 3; i++) begin
      drive(1, cmds[i], 32'd3, 32'd4, 0, 5'd6, 3'b001);
      #1;
      n_chk++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL nomdu_stall cmd=%h got %b want 0", cmds[i], stall); end
      tick();
      n_chk++;
      if (ALU_result !== 32'd0 || WB_EN !== 1'b1 || Dest !== 5'd6) begin
        n_fail++; $display("FAIL nomdu_result cmd=%h got %h wb=%b d=%0d want 0 1 6", cmds[i], ALU_result, WB_EN, Dest);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_add_wrap();
    test_alu_random();
    test_branch();
    test_reset_mid();
`ifdef EXE_MDU_EN
    test_mdu();
    test_back_to_back();
    test_reset_busy();
`else
    test_no_mdu();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
